// File: rtl/dm_pkg.sv
// dm_byte shared definitions: DMOp codes, FSM states, lane helpers.
// Optional build macro used by dm_byte: DM_MISALIGN_TRAP_EN.
package dm_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_H) || (op == OP_HU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_B) || (op == OP_H) || (op == OP_W);
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] op,
    input logic [1:0] lane
  );
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      OP_B:    be = 4'b0001 << lane;
      OP_H:    be = 4'b0011 << {lane[1], 1'b0};
      OP_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_byte_ext.sv
// dm_ext: lane extract and sign/zero extension of a raw memory word.
// Purely combinational; reserved DMOp codes yield zero.
module dm_ext
  import dm_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] data
);

  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;

  always_comb begin
    b    = word[{lane, 3'b000} +: BYTE_W];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (op)
      OP_B:    data = {{24{b[7]}}, b};
      OP_H:    data = {{16{h[15]}}, h};
      OP_W:    data = word;
      OP_BU:   data = {24'd0, b};
      OP_HU:   data = {16'd0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_byte.sv
// Byte-addressable data memory with post-reset clear sweep.
// Build macro DM_MISALIGN_TRAP_EN enables misalignment trapping.
module dm_byte
  import dm_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W+1:0] Ad,
  input  logic [31:0]       WrData,
  input  logic              DMWr,
  input  logic              DMRd,
  input  logic [2:0]        DMOp,
  output logic [31:0]       DM,
  output logic              RdValid,
`ifdef DM_MISALIGN_TRAP_EN
  output logic              Misalign,
`endif
  output logic              Busy
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic              mis;
  logic              idle;
  logic              st_ok;
  logic              ld_ok;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       ld_data;

  assign widx = Ad[ADDR_W+1:2];
  assign idle = (state == IDLE);
  assign Busy = (state == CLEAR);

  // Without trapping, offending low bits are dropped so access stays aligned.
  always_comb begin
    lane = Ad[1:0];
    mis  = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    mis = (is_half(DMOp) && Ad[0]) ||
          ((DMOp == OP_W) && (Ad[1:0] != 2'b00));
`else
    if (DMOp == OP_W) lane = 2'b00;
    else if (is_half(DMOp)) lane[0] = 1'b0;
`endif
  end

  assign st_ok = idle && DMWr && is_store(DMOp) && !mis;
  assign ld_ok = idle && DMRd && !DMWr && !mis;
  assign be    = lane_be(DMOp, lane);
  assign wd    = WrData << {lane, 3'b000};

  dm_ext u_ext (
    .lane (lane),
    .op   (DMOp),
    .word (mem[widx]),
    .data (ld_data)
  );

  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (st_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      DM      <= '0;
      RdValid <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= IDLE;
      end
      RdValid <= ld_ok;
      if (ld_ok) DM <= ld_data;
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Misalign <= 1'b0;
    else       Misalign <= idle && (DMWr || DMRd) && mis;
  end
`endif

endmodule

// File: tb/tb_dm_byte.sv
// Self-checking bench for dm_byte: directed plan plus random traffic
// against a byte-array reference model.
module tb_dm_byte;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Ad = '0;
  logic [31:0] WrData = '0;
  logic        DMWr = 1'b0;
  logic        DMRd = 1'b0;
  logic [2:0]  DMOp = '0;
  logic [31:0] DM;
  logic        RdValid;
  logic        Busy;
  logic        mis_obs;

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
  logic Misalign;
  assign mis_obs = Misalign;
`else
  localparam bit TRAP = 1'b0;
  assign mis_obs = 1'b0;
`endif

  dm_byte #(.ADDR_W(6)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Ad      (Ad),
    .WrData  (WrData),
    .DMWr    (DMWr),
    .DMRd    (DMRd),
    .DMOp    (DMOp),
    .DM      (DM),
    .RdValid (RdValid),
`ifdef DM_MISALIGN_TRAP_EN
    .Misalign(Misalign),
`endif
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mref [256];
  logic [31:0] last_dm = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [2:0] op);
    int sz;
    longint v;
    int base;
    sz = op_size(op);
    if (sz == 0) return 32'd0;
    base = a - (a % sz);
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(mref[base + i]) << (8 * i);
    if (op == 3'b000 && v >= 128)   v -= 256;
    if (op == 3'b001 && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic model_store(input int a, input logic [2:0] op,
                             input logic [31:0] d);
    int sz;
    int base;
    sz = op_size(op);
    if (sz == 0 || op[2]) return;
    base = a - (a % sz);
    for (int i = 0; i < sz; i++) mref[base + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  // One request cycle in IDLE, checked 1 time unit after the edge.
  task automatic cyc(input string tag, input logic wr, input logic rd,
                     input logic [7:0] a, input logic [2:0] op,
                     input logic [31:0] d);
    int  sz;
    bit  mis;
    bit  exp_rv;
    @(negedge Clk);
    DMWr = wr; DMRd = rd; Ad = a; DMOp = op; WrData = d;
    sz  = op_size(op);
    mis = TRAP && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    exp_rv = 1'b0;
    if (wr) begin
      if (!mis) model_store(int'(a), op, d);
    end else if (rd && !mis) begin
      exp_rv  = 1'b1;
      last_dm = model_load(int'(a), op);
    end
    @(posedge Clk);
    #1;
    check({tag, ".rv"}, 32'(RdValid), 32'(exp_rv));
    check({tag, ".dm"}, DM, last_dm);
    check({tag, ".busy"}, 32'(Busy), 32'd0);
    if (TRAP) check({tag, ".mis"}, 32'(mis_obs), 32'((wr || rd) && mis));
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0);
  endtask

  task automatic do_reset(input bit store_in_busy);
    int n;
    @(negedge Clk);
    Reset = 1'b1; DMWr = 1'b0; DMRd = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst.dm", DM, 32'h0);
    check("rst.rv", 32'(RdValid), 32'd0);
    check("rst.busy", 32'(Busy), 32'd1);
    for (int i = 0; i < 256; i++) mref[i] = 8'h00;
    last_dm = '0;
    @(negedge Clk);
    Reset = 1'b0;
    if (store_in_busy) begin
      DMWr = 1'b1; DMOp = 3'b010; Ad = 8'h30; WrData = 32'hDEADBEEF;
    end
    n = 0;
    while (Busy && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
      @(negedge Clk);
      DMWr = 1'b0;
    end
    check("busy_len", 32'(n), 32'd64);
  endtask

  initial begin
    do_reset(1'b0);
    for (int i = 0; i < 8; i++)
      cyc("clr_lw", 1'b0, 1'b1, 8'($urandom_range(0, 63) * 4), 3'b010, 32'h0);

    cyc("sw08", 1'b1, 1'b0, 8'h08, 3'b010, 32'h11223344);
    cyc("lb08", 1'b0, 1'b1, 8'h08, 3'b000, 32'h0);
    check("lb08.val", DM, 32'h00000044);
    idle_cyc("lb08.drop");
    cyc("lb0b", 1'b0, 1'b1, 8'h0B, 3'b000, 32'h0);
    check("lb0b.val", DM, 32'h00000011);
    cyc("lhu0a", 1'b0, 1'b1, 8'h0A, 3'b101, 32'h0);
    check("lhu0a.val", DM, 32'h00001122);
    idle_cyc("lhu0a.drop");

    cyc("sw10", 1'b1, 1'b0, 8'h10, 3'b010, 32'hFFFFFFFF);
    cyc("sb11", 1'b1, 1'b0, 8'h11, 3'b000, 32'h00000080);
    cyc("lw10", 1'b0, 1'b1, 8'h10, 3'b010, 32'h0);
    check("lw10.val", DM, 32'hFFFF80FF);
    cyc("lb11", 1'b0, 1'b1, 8'h11, 3'b000, 32'h0);
    check("lb11.val", DM, 32'hFFFFFF80);
    cyc("lbu11", 1'b0, 1'b1, 8'h11, 3'b100, 32'h0);
    check("lbu11.val", DM, 32'h00000080);

    cyc("wr_rd20", 1'b1, 1'b1, 8'h20, 3'b010, 32'hA5A5A5A5);
    cyc("lw20", 1'b0, 1'b1, 8'h20, 3'b010, 32'h0);
    check("lw20.val", DM, 32'hA5A5A5A5);

    cyc("rsv_ld", 1'b0, 1'b1, 8'h20, 3'b011, 32'h0);
    check("rsv_ld.val", DM, 32'h0);
    cyc("rsv_st", 1'b1, 1'b0, 8'h20, 3'b111, 32'h0);
    cyc("rsv_lw", 1'b0, 1'b1, 8'h20, 3'b010, 32'h0);

    cyc("sw04", 1'b1, 1'b0, 8'h04, 3'b010, 32'h12345678);
    cyc("lw06", 1'b0, 1'b1, 8'h06, 3'b010, 32'h0);
    cyc("sh05", 1'b1, 1'b0, 8'h05, 3'b001, 32'h0000BEEF);
    cyc("lw04", 1'b0, 1'b1, 8'h04, 3'b010, 32'h0);

    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (30) @(posedge Clk);
    do_reset(1'b1);
    cyc("lw30", 1'b0, 1'b1, 8'h30, 3'b010, 32'h0);
    check("lw30.val", DM, 32'h0);
    cyc("lw08r", 1'b0, 1'b1, 8'h08, 3'b010, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      logic [1:0] kind;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) op = (op[0]) ? 3'b001 : (op[1] ? 3'b010 : op);
      kind = 2'($urandom_range(0, 3));
      cyc("rnd", kind[0], kind[1] | ~kind[0], 8'($urandom_range(0, 255)),
          op, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_byte.md
# dm_byte

Parametrised byte-addressable data memory for the single-cycle/multi-cycle CPU datapath, replacing the word-only data memory. It supports byte/halfword/word loads and stores with sign or zero extension and a registered one-cycle read. After reset it runs a hardware clear sweep instead of a file load. Optional misalignment trapping is provided. It sits between the ALU address output and the write-back mux.

## Interface
Parameters:
- `ADDR_W`, default 6: word-address width; depth is 2**ADDR_W 32-bit words.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Ad`  in  ADDR_W+2  byte address; [1:0] selects the byte lane, [ADDR_W+1:2] selects the word.
- `WrData`  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- `DMWr`  in  1  store request.
- `DMRd`  in  1  load request.
- `DMOp`  in  3  access size and sign, encoded per `dm_pkg`.
- `DM`  out  32  load result, extended to 32 bits.
- `RdValid`  out  1  one-cycle pulse; `DM` holds new load data.
- `Busy`  out  1  clear sweep in progress; requests are ignored.
- `Misalign`  out  1  registered misalignment flag; present only with the macro.

## Operation
- State machine `CLEAR` -> `IDLE`.
- `Reset` high: state forced to `CLEAR`, sweep counter set to 0, `DM`=0, `RdValid`=0, `Misalign`=0, `Busy`=1.
- `CLEAR`: each cycle writes 0 to the word at the counter, then increments the counter. When the counter equals 2**ADDR_W-1, the sweep writes that word and moves to `IDLE`; `Busy` drops.
- Reset asserted mid-sweep restarts the sweep from word 0.
- `IDLE` store (`DMWr`=1): byte-lane merge into the addressed word.
  - SB writes lane `Ad[1:0]`.
  - SH writes lanes {`Ad[1]`,0} and {`Ad[1]`,1}.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- `IDLE` load (`DMRd`=1): the addressed word is read and the lane is extracted by `Ad[1:0]`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Result is registered into `DM` and `RdValid` pulses.
- `DMWr` and `DMRd` high together: the store executes, the load is dropped, and `RdValid` stays 0.
- Any request while `Busy`=1 is dropped with no side effects.
- Reserved `DMOp` codes: a store is ignored; a load returns 0 with `RdValid`=1.
- `DM` holds its last value until the next valid load.
- Endianness is little: lane 0 is bits [7:0].

## Timing
- Load latency is 1 cycle. A request sampled at edge N gives `DM`/`RdValid` valid after edge N; `RdValid` is low again after edge N+1 unless a new load is issued.
- A store commits at the edge where it is sampled. A load issued on the next cycle to the same address returns the new data.
- Back-to-back loads on every cycle are supported at full throughput.
- Clear sweep takes exactly 2**ADDR_W cycles after `Reset` falls, so `Busy`=1 for that many rising edges (64 with the default).
- Address wrap: `Ad` is truncated to ADDR_W+2 bits, with no out-of-range detection.

## Configuration
- Macro: `DM_MISALIGN_TRAP_EN`.
- Defined:
  - Half accesses with `Ad[0]`=1 and word accesses with `Ad[1:0]`≠0 are misaligned.
  - A misaligned store is suppressed.
  - A misaligned load gives no `RdValid` pulse.
  - `Misalign` pulses for one cycle, with the same latency as `RdValid`.
- Undefined:
  - The `Misalign` port is absent.
  - Offending low address bits are forced to 0: word uses `Ad[1:0]`=0, half uses `Ad[0]`=0.
  - The access proceeds aligned.

## Structure
- Package `dm_pkg`:
  - `DMOp` encodings: LB/SB=3'b000, LH/SH=3'b001, LW/SW=3'b010, LBU=3'b100, LHU=3'b101; all others reserved.
  - State enum `CLEAR`/`IDLE`.
  - Lane-width constants.
- Sub-module `dm_ext`: combinational lane extract plus sign/zero extend, driven by `Ad[1:0]`, `DMOp` and the raw word. `dm_byte` owns the storage, the FSM and the store merge.

## Test plan
- Reset for 3 cycles, then release. `Busy` is high for exactly 64 cycles. Every later LW returns 0x00000000.
- SW 0x11223344 @0x08. Then:
  - LB @0x08 -> 0x00000044.
  - LB @0x0B -> 0x00000011.
  - LHU @0x0A -> 0x00001122.
  - `RdValid` pulses once per load.
- SW 0xFFFFFFFF @0x10, then SB 0x80 @0x11. LW @0x10 -> 0xFFFF80FF. LB @0x11 -> 0xFFFFFF80. LBU @0x11 -> 0x00000080.
- `DMWr`+`DMRd` together at 0x20 with data 0xA5A5A5A5. No `RdValid`; a following LW @0x20 -> 0xA5A5A5A5.
- Assert `Reset` at sweep cycle 30, then release. `Busy` lasts 64 more cycles. A store issued during `Busy` is lost (readback 0).
- With the macro, LW @0x06 -> `Misalign` pulse, no `RdValid`. SH 0xBEEF @0x05 leaves memory unchanged. Without the macro, LW @0x06 returns the word @0x04.
